// File: rtl/ul4_pkg.sv
// Shared constants and enumerations for the 4-bit logic unit and its accumulator stage.
package ul4_pkg;

    localparam int DW = 4;

    typedef enum logic [2:0] {
        OP_LDI = 3'b000,
        OP_AND = 3'b001,
        OP_OR  = 3'b010,
        OP_XOR = 3'b011,
        OP_NOT = 3'b100,
        OP_ST  = 3'b101,
        OP_LDR = 3'b110,
        OP_NOP = 3'b111
    } op_e;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;
    localparam logic [1:0] SEL_NOT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    // ST and NOP leave the accumulator and zero flag untouched.
    function automatic logic writes_acc(input op_e o);
        return !(o inside {OP_ST, OP_NOP});
    endfunction

endpackage

// File: rtl/ul4.sv
// 4-bit logic unit: AND / OR / XOR of a and b, or NOT of a, chosen by s.
// Purely combinational; no flow control.
module ul4
    import ul4_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [1:0]    s,
    output logic [DW-1:0] y
);

    always_comb begin
        y = '0;
        case (s)
            SEL_AND: y = a & b;
            SEL_OR:  y = a | b;
            SEL_XOR: y = a ^ b;
            default: y = ~a;
        endcase
    end

endmodule

// File: rtl/ul4_acc.sv
// Accumulator stage around ul4 with a small register file, one instruction per 3 cycles.
// Write-back two edges after accept, done pulses the cycle after; in_ready only in IDLE.
module ul4_acc
    import ul4_pkg::*;
#(
    parameter  int NREG = 4,
    localparam int RW   = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    op,
    input  logic [RW-1:0] rsel,
    input  logic [DW-1:0] imm,
    output logic [DW-1:0] acc,
    output logic          zero,
    output logic          done
);

    state_e          state_q, state_d;
    op_e             op_q;
    logic [RW-1:0]   rsel_q;
    logic [DW-1:0]   imm_q;
    logic [DW-1:0]   res_q, res_d;
    logic [DW-1:0]   acc_q;
    logic            zero_q;
    logic            done_q;
    logic [DW-1:0]   rf_q [NREG];
    logic [DW-1:0]   rf_rd;
    logic [DW-1:0]   alu_y;
    logic [1:0]      sel;
    logic            rsel_ok;
    logic            hs;

    // Out-of-range indices (non power-of-two NREG) read as zero and drop writes.
    assign rsel_ok = int'(rsel_q) < NREG;
    assign rf_rd   = rsel_ok ? rf_q[rsel_q] : '0;
    assign hs      = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = !reset;
                if (in_valid && !reset) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= OP_NOP;
            rsel_q <= '0;
            imm_q  <= '0;
        end else if (hs) begin
            op_q   <= op_e'(op);
            rsel_q <= rsel;
            imm_q  <= imm;
        end
    end

    ul4 u_ul4 (
        .a (acc_q),
        .b (rf_rd),
        .s (sel),
        .y (alu_y)
    );

    // Result source: logic ops take the unit output, moves take their operand directly.
    always_comb begin
        sel   = SEL_AND;
        res_d = alu_y;
        case (op_q)
            OP_AND:  sel = SEL_AND;
            OP_OR:   sel = SEL_OR;
            OP_XOR:  sel = SEL_XOR;
            OP_NOT:  sel = SEL_NOT;
            OP_LDI:  res_d = imm_q;
            OP_LDR:  res_d = rf_rd;
            OP_ST:   res_d = acc_q;
            default: res_d = acc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q <= '0;
        end else if (state_q == ST_EXEC) begin
            res_q <= res_d;
        end
    end

    // Reset in EXEC/WB returns to IDLE before this block ever sees WB, aborting the op.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            zero_q <= 1'b1;
            done_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            done_q <= (state_q == ST_WB);
            if (state_q == ST_WB) begin
                if (writes_acc(op_q)) begin
                    acc_q  <= res_q;
                    zero_q <= (res_q == '0);
                end
                if (op_q == OP_ST && rsel_ok) begin
                    rf_q[rsel_q] <= res_q;
                end
            end
        end
    end

    assign acc  = acc_q;
    assign zero = zero_q;
    assign done = done_q;

endmodule

// File: tb/tb_ul4_acc.sv
// Scoreboard bench for ul4_acc: expectations pushed at accept, compared at done.
module tb_ul4_acc;
    import ul4_pkg::*;

    localparam int NREG = 4;
    localparam int RW   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    op = 3'b111;
    logic [RW-1:0] rsel = '0;
    logic [3:0]    imm = '0;
    logic [3:0]    acc;
    logic          zero;
    logic          done;

    ul4_acc #(.NREG(NREG)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rsel     (rsel),
        .imm      (imm),
        .acc      (acc),
        .zero     (zero),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] acc;
        logic       zero;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_pop;
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         n_acc = 0;
    int         n_done = 0;
    logic [3:0] m_acc = 4'h0;
    logic       m_zero = 1'b1;
    logic [3:0] m_rf [NREG];

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc  = 4'h0;
        m_zero = 1'b1;
        for (int i = 0; i < NREG; i++) m_rf[i] = 4'h0;
        sb.delete();
    endtask

    task automatic model_step(input logic [2:0] o, input logic [RW-1:0] r, input logic [3:0] i);
        exp_t e;
        case (o)
            3'b000: begin m_acc = i;               m_zero = (m_acc == 4'h0); end
            3'b001: begin m_acc = m_acc & m_rf[r]; m_zero = (m_acc == 4'h0); end
            3'b010: begin m_acc = m_acc | m_rf[r]; m_zero = (m_acc == 4'h0); end
            3'b011: begin m_acc = m_acc ^ m_rf[r]; m_zero = (m_acc == 4'h0); end
            3'b100: begin m_acc = ~m_acc;          m_zero = (m_acc == 4'h0); end
            3'b101: m_rf[r] = m_acc;
            3'b110: begin m_acc = m_rf[r];         m_zero = (m_acc == 4'h0); end
            default: ;
        endcase
        e.acc  = m_acc;
        e.zero = m_zero;
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    // Monitor: retire first (pop), then record a new accept in the same cycle.
    always @(negedge clk) begin
        cyc++;
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk_eq("done_unexpected", done, 1'b0);
            end else begin
                e_pop = sb.pop_front();
                chk_eq("sb_acc", acc, e_pop.acc);
                chk_eq("sb_zero", zero, e_pop.zero);
                chk_eq("sb_latency", cyc - e_pop.cyc, 3);
            end
        end
        if (in_valid && in_ready) begin
            n_acc++;
            model_step(op, rsel, imm);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [RW-1:0] r, input logic [3:0] i);
        int n;
        n = 0;
        @(posedge clk); #1;
        in_valid = 1'b1;
        op = o;
        rsel = r;
        imm = i;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk_eq("handshake_timeout", in_ready, 1'b1);
        @(posedge clk); #1;
        // Scramble operands during EXEC; the captured copy must be used.
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7));
        rsel = RW'($urandom_range(0, 3));
        imm = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        chk_eq("drain_empty", sb.size(), 0);
    endtask

    task automatic run(input logic [2:0] o, input logic [RW-1:0] r, input logic [3:0] i);
        issue(o, r, i);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int d0;
        model_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk_eq("post_rst_acc", acc, 4'h0);
        chk_eq("post_rst_zero", zero, 1'b1);
        chk_eq("post_rst_done", done, 1'b0);
        chk_eq("post_rst_in_ready", in_ready, 1'b1);

        run(OP_LDI, 2'd0, 4'b0010);
        run(OP_ST,  2'd1, 4'h0);
        run(OP_LDI, 2'd0, 4'b1010);
        run(OP_AND, 2'd1, 4'h0);
        chk_eq("and_acc", acc, 4'b0010);
        chk_eq("and_zero", zero, 1'b0);

        run(OP_LDI, 2'd0, 4'b1000);
        run(OP_OR,  2'd1, 4'h0);
        chk_eq("or_acc", acc, 4'b1010);
        run(OP_LDI, 2'd0, 4'b0010);
        run(OP_XOR, 2'd1, 4'h0);
        chk_eq("xor_acc", acc, 4'b0000);
        chk_eq("xor_zero", zero, 1'b1);

        run(OP_LDI, 2'd0, 4'b0010);
        run(OP_NOT, 2'd2, 4'h0);
        chk_eq("not_acc", acc, 4'b1101);
        chk_eq("not_zero", zero, 1'b0);
        d0 = n_done;
        run(OP_NOP, 2'd0, 4'h0);
        chk_eq("nop_acc", acc, 4'b1101);
        chk_eq("nop_zero", zero, 1'b0);
        chk_eq("nop_done", n_done - d0, 1);

        a0 = n_acc;
        d0 = n_done;
        @(posedge clk); #1;
        in_valid = 1'b1;
        op = OP_LDI;
        imm = 4'b0101;
        repeat (6) @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        chk_eq("hold_accepts", n_acc - a0, 2);
        chk_eq("hold_dones", n_done - d0, 2);
        chk_eq("hold_acc", acc, 4'b0101);

        run(OP_LDI, 2'd0, 4'b0110);
        run(OP_ST,  2'd3, 4'h0);
        issue(OP_LDI, 2'd0, 4'b1111);
        reset = 1'b1;
        model_reset();
        d0 = n_done;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_eq("abort_acc", acc, 4'h0);
        chk_eq("abort_zero", zero, 1'b1);
        chk_eq("abort_no_done", n_done - d0, 0);
        run(OP_LDR, 2'd3, 4'h0);
        chk_eq("ldr_r3_acc", acc, 4'h0);
        chk_eq("ldr_r3_zero", zero, 1'b1);
        run(OP_LDR, 2'd1, 4'h0);
        chk_eq("ldr_r1_acc", acc, 4'h0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ul4_acc.md
UL4_ACC -- requirements
Module: ul4_acc

Interface
REQ-001 Parameter NREG, default 4, number of general registers; RW = clog2(NREG).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  an instruction is presented on op/rsel/imm.
REQ-005 in_ready  output  1  block accepts an instruction this cycle.
REQ-006 op  input  3  opcode: 000 LDI, 001 AND, 010 OR, 011 XOR, 100 NOT, 101 ST, 110 LDR, 111 NOP.
REQ-007 rsel  input  RW  register index for AND/OR/XOR/ST/LDR.
REQ-008 imm  input  4  immediate operand for LDI.
REQ-009 acc  output  4  accumulator contents.
REQ-010 zero  output  1  last accumulator write produced 0000.
REQ-011 done  output  1  one-cycle pulse marking instruction retirement.

Function
REQ-012 The block SHALL be an accumulator stage that drives the existing 4-bit logic unit ul4 (A = acc, B = rf[rsel_q], S = select) and consumes its 4-bit output.
REQ-013 The FSM SHALL have states IDLE, EXEC, WB; in_ready = 1 only in IDLE and not in reset.
REQ-014 A handshake (in_valid & in_ready at an edge) SHALL capture op, rsel, imm into internal registers and move IDLE->EXEC; otherwise the FSM stays in IDLE.
REQ-015 EXEC->WB SHALL be unconditional; on that edge the ul4 output (or the LDI/LDR/ST source value) is registered into res_q.
REQ-016 WB->IDLE SHALL be unconditional; on that edge the write-back occurs and done is set, so done is high for exactly the one cycle following the WB edge.
REQ-017 Latency: accept at edge E0, write-back at edge E0+2; throughput one instruction per 3 cycles.
REQ-018 Select mapping to ul4: AND->00, OR->01, XOR->10, NOT->11 (NOT inverts acc only; B ignored).
REQ-019 LDI: acc <= imm_q. LDR: acc <= rf[rsel_q]. AND/OR/XOR/NOT: acc <= ul4 result.
REQ-020 ST: rf[rsel_q] <= acc; acc and zero unchanged.
REQ-021 NOP: no register or flag change; done still pulses.
REQ-022 zero SHALL be updated only when acc is written, to (new acc == 0000).
REQ-023 op/rsel/imm SHALL be sampled only at the handshake; changes during EXEC/WB have no effect.
REQ-024 in_valid held high through EXEC/WB SHALL not cause extra execution; a new handshake is possible only once back in IDLE.
REQ-025 rsel values >= NREG (when NREG is not a power of 2) SHALL read 0000 and discard writes.

Reset
REQ-026 While reset is high at an edge: state <= IDLE, acc <= 0000, all rf entries <= 0000, zero <= 1, done <= 0.
REQ-027 in_ready SHALL be 0 while reset is high and 1 in the first cycle after release.
REQ-028 Reset during EXEC or WB SHALL abort the instruction: no write-back, no done pulse.

Structure
REQ-029 A shared package ul4_pkg SHALL hold the 4-bit data width constant, the opcode enumeration, the ul4 select encodings, and the FSM state enumeration.
REQ-030 ul4 SHALL be instantiated unchanged as the single sub-module; the register file and FSM are local to ul4_acc.

Verification
REQ-031 Reset for 2 cycles, release -> acc=0000, zero=1, done=0, in_ready=1 on first post-reset cycle.
REQ-032 LDI 0010; ST r1; LDI 1010; AND r1 -> acc=0010, zero=0; each done exactly 3 cycles after its accept.
REQ-033 With r1=0010: LDI 1000; OR r1 -> acc=1010; LDI 0010; XOR r1 -> acc=0000, zero=1.
REQ-034 LDI 0010; NOT -> acc=1101, zero=0; NOP -> acc=1101, zero=0, done pulses.
REQ-035 in_valid held high for 6 cycles with op=LDI imm=0101 -> exactly 2 instructions accepted, 2 done pulses, acc=0101.
REQ-036 LDI 1111 accepted, reset asserted in EXEC -> acc=0000, zero=1, no done; LDR r3 afterwards -> acc=0000, zero=1.
